// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into 32-bit words
// behind a single valid/ready holding register. Illegal bundles are consumed
// and counted, never emitted. Emitted words carry their target byte address.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpAluReg = 7'b0110011;

  localparam logic [ADDR_WIDTH-1:0] IdxOne = 1;

  logic                  out_valid_q;
  logic [31:0]           out_instr_q;
  logic [ADDR_WIDTH-1:0] word_index_q;
  logic                  err_q;
  logic [7:0]            err_count_q;

  logic        legal;
  logic [31:0] instr_d;
  logic [6:0]  shift_f7;
  logic        out_hs;
  logic        accept;

  assign shift_f7  = {1'b0, alt, 5'b0};
  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign out_hs    = out_valid_q && out_ready;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = BASE_ADDR + 32'({word_index_q, 2'b00});
  assign err       = err_q;
  assign err_count = err_count_q;

  // Validate the bundle and pack it into the format of its instruction class.
  always_comb begin
    legal   = 1'b1;
    instr_d = 32'h0;
    unique case (op_class)
      4'd0: instr_d = {imm[31:12], rd, OpLui};
      4'd1: instr_d = {imm[31:12], rd, OpAuipc};
      4'd2: begin
        legal   = !imm[0];
        instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
      end
      4'd3: instr_d = {imm[11:0], rs1, 3'b000, rd, OpJalr};
      4'd4: begin
        legal   = !imm[0] && (funct3 != 3'b010) && (funct3 != 3'b011);
        instr_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
      end
      4'd5: begin
        legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        instr_d = {imm[11:0], rs1, funct3, rd, OpLoad};
      end
      4'd6: begin
        legal   = funct3 < 3'b011;
        instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpStore};
      end
      4'd7: begin
        // Only SRAI may set alt; this also rejects alt on SLLI.
        legal = !alt || (funct3 == 3'b101);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          instr_d = {shift_f7, imm[4:0], rs1, funct3, rd, OpAluImm};
        end else begin
          instr_d = {imm[11:0], rs1, funct3, rd, OpAluImm};
        end
      end
      4'd8: begin
        legal   = !alt || (funct3 == 3'b000) || (funct3 == 3'b101);
        instr_d = {shift_f7, rs2, rs1, funct3, rd, OpAluReg};
      end
      default: legal = 1'b0;
    endcase
  end

  // Holding register, word address counter and rejection bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'h0;
      word_index_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= 8'h0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      word_index_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= 8'h0;
    end else begin
      if (out_hs) begin
        word_index_q <= word_index_q + IdxOne;
      end
      err_q <= accept && !legal;
      if (accept && !legal && err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder that turns decoded instruction fields back into 32-bit instruction words, the inverse of the core's control decode. It sits between the test/program generator and instruction memory. It accepts one field bundle per valid/ready handshake, validates and packs it into one pipeline register, and emits the word with its target byte address. Illegal bundles are dropped and counted.

## Interface
- ADDR_WIDTH, 8, width of the word-index counter (memory depth 2^ADDR_WIDTH words)
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- clear  in  1  synchronous: reset the address counter and error count, drop the held word
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept this cycle
- op_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ALU_IMM, 8 ALU_REG, 9–15 illegal
- funct3  in  3  funct3 field
- alt  in  1  funct7[5] (SUB/SRA/SRAI select)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  immediate, byte-offset semantics as in the ISA
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  encoded instruction
- out_addr  out  32  BASE_ADDR + 4*word_index
- err  out  1  one-cycle pulse: a bundle was rejected
- err_count  out  8  rejected bundles, saturating at 255

## Operation
- Accept when in_valid && in_ready. Set in_ready = !out_valid || out_ready. There is one holding register, so full throughput holds under continuous out_ready.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALU_IMM 0010011, ALU_REG 0110011.
- Formats. Unused fields are zero. Immediate bits outside the field are ignored.
  - U (LUI/AUIPC): imm[31:12].
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]}.
  - I (JALR/LOAD/ALU_IMM): imm[11:0].
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
- JALR funct3 is forced to 000, and the input funct3 is ignored.
- Shifts:
  - ALU_IMM with funct3 001/101 uses {1'b0, alt, 5'b0} as bits 31:25 and imm[4:0] as shamt.
  - ALU_REG uses funct7 = {1'b0, alt, 5'b0}.
- Illegal bundles are accepted (the handshake completes) but not emitted. The bundle is illegal when any of these holds:
  - op_class ≥ 9
  - BRANCH with f3 ∈ {010, 011}
  - LOAD with f3 ∈ {011, 110, 111}
  - STORE with f3 ≥ 011
  - JAL/BRANCH with imm[0]=1
  - alt=1 in ALU_IMM unless f3=101
  - alt=1 in ALU_REG unless f3 ∈ {000, 101}
  - alt=1 with ALU_IMM f3=001
- On an illegal accept: err pulses the next cycle, err_count increments (saturating), and out_valid and word_index are unchanged.
- word_index advances by 1 on each output handshake (out_valid && out_ready). It wraps modulo 2^ADDR_WIDTH, so out_addr returns to BASE_ADDR.

## Timing
- Latency is 1 cycle: a bundle accepted in cycle N appears on out_* in cycle N+1.
- out_instr and out_addr are stable while out_valid && !out_ready.
- A simultaneous output handshake and new accept replaces the word without a bubble. out_addr for the new word is the incremented index.
- clear has priority over all activity in its cycle:
  - out_valid → 0, word_index → 0, err_count → 0, err → 0.
  - in_ready is forced to 0 that cycle.
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, err_count 0, word_index 0. in_ready is 1 from the first cycle after rst deasserts.
- Reset mid-transfer discards the held word. No partial state survives.

## Test plan
- ALU_IMM addi x1,x0,5 (f3 000, imm 5, rd 1), out_ready=1 → out_instr 0x00500093, out_addr 0x0 one cycle later.
- Back-to-back stream:
  - Bundles: sub x3,x1,x2; jal x1,+8; beq x1,x2,-4; sw x2,8(x1).
  - Required: 0x402081B3, 0x008000EF, 0xFE208EE3, 0x0020A423 on consecutive cycles, at addresses 0x0/0x4/0x8/0xC.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 and out_instr stable throughout.
  - Release out_ready: the next word follows with no loss or duplication.
- Illegal bundles: op_class 12, then LOAD f3 111, then ALU_REG alt=1 f3 111.
  - Three err pulses, err_count=3, no out_valid.
  - The next legal word gets the unchanged address.
- Wrap with ADDR_WIDTH=2: emit 5 words.
  - Addresses 0x0, 0x4, 0x8, 0xC, 0x0.
  - clear mid-stream resets the next address to BASE_ADDR.
- Assert rst while out_valid=1 → outputs return to reset values asynchronously, and the held word is never emitted.
